// File: rtl/jogo_memoria_param.sv
// Parametrised sequence-memory game controller: N one-hot buttons, external sync ROM.
// Optional per-play timeout enabled by defining JOGO_MEMORIA_TIMEOUT_EN.
module jogo_memoria_param #(
  parameter int N_BOTOES       = 4,
  parameter int N_RODADAS      = 16,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int LARG_END       = (N_RODADAS > 1) ? $clog2(N_RODADAS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [N_BOTOES-1:0] mem_dado,
  output logic [LARG_END-1:0] mem_endereco,
  output logic [N_BOTOES-1:0] leds,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                timeout,
  output logic [3:0]          db_estado,
  output logic [LARG_END-1:0] db_rodada,
  output logic                db_jogada_correta
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_GANHOU     = 4'hA,
    FIM_PERDEU     = 4'hE,
    FIM_TIMEOUT    = 4'hF
  } estado_t;

  localparam logic [LARG_END-1:0] ULTIMA_RODADA = LARG_END'(N_RODADAS - 1);

  estado_t             estado, proximo;
  logic [N_BOTOES-1:0] botoes_ant;
  logic [N_BOTOES-1:0] jogada;
  logic [N_BOTOES-1:0] leds_r;
  logic [LARG_END-1:0] rodada;
  logic [LARG_END-1:0] indice;
  logic                correta_r;
  logic                evento;
  logic                correta;
  logic                expirou;

  // A press is a rising edge of "any button down"; holding never re-triggers.
  assign evento  = (botoes != '0) && (botoes_ant == '0);
  assign correta = (jogada == mem_dado) && (jogada != '0) &&
                   ((jogada & (jogada - N_BOTOES'(1))) == '0);

`ifdef JOGO_MEMORIA_TIMEOUT_EN
  localparam int LARG_TMO = $clog2(TIMEOUT_CICLOS);
  logic [LARG_TMO-1:0] cont_tmo;

  always_ff @(posedge clock) begin
    if (reset || (estado != ESPERA_JOGADA)) cont_tmo <= '0;
    else if (!expirou)                      cont_tmo <= cont_tmo + LARG_TMO'(1);
  end

  assign expirou = (cont_tmo == LARG_TMO'(TIMEOUT_CICLOS - 1));
  assign timeout = (estado == FIM_TIMEOUT);
`else
  // Without the timer the parameter has no effect; the compare is always false.
  assign expirou = (TIMEOUT_CICLOS < 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT:
        if (jogar) proximo = PREPARACAO;
      PREPARACAO:     proximo = INICIA_RODADA;
      INICIA_RODADA:  proximo = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (evento)       proximo = REGISTRA;
        else if (expirou) proximo = FIM_TIMEOUT;
      end
      REGISTRA:       proximo = COMPARA;
      COMPARA: begin
        if (!correta)                    proximo = FIM_PERDEU;
        else if (indice < rodada)        proximo = PROXIMA_JOGADA;
        else if (rodada == ULTIMA_RODADA) proximo = FIM_GANHOU;
        else                             proximo = PROXIMA_RODADA;
      end
      PROXIMA_JOGADA: proximo = ESPERA_JOGADA;
      PROXIMA_RODADA: proximo = INICIA_RODADA;
      default:        proximo = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      botoes_ant <= '0;
      jogada     <= '0;
      leds_r     <= '0;
      rodada     <= '0;
      indice     <= '0;
      correta_r  <= 1'b0;
    end else begin
      botoes_ant <= botoes;
      case (estado)
        PREPARACAO: begin
          jogada    <= '0;
          leds_r    <= '0;
          rodada    <= '0;
          indice    <= '0;
          correta_r <= 1'b0;
        end
        INICIA_RODADA:  indice <= '0;
        ESPERA_JOGADA:  if (evento) jogada <= botoes;
        REGISTRA:       leds_r <= jogada;
        COMPARA:        correta_r <= correta;
        PROXIMA_JOGADA: indice <= indice + LARG_END'(1);
        PROXIMA_RODADA: rodada <= rodada + LARG_END'(1);
        default: ;
      endcase
    end
  end

  // The play index doubles as the ROM address, so it is registered by construction.
  assign mem_endereco      = indice;
  assign leds              = leds_r;
  assign pronto            = (estado == FIM_GANHOU) || (estado == FIM_PERDEU) ||
                             (estado == FIM_TIMEOUT);
  assign ganhou            = (estado == FIM_GANHOU);
  assign perdeu            = (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
  assign db_estado         = estado;
  assign db_rodada         = rodada;
  assign db_jogada_correta = correta_r;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed bench for jogo_memoria_param: 4-button/4-round instance plus an
// 8-button/1-round instance, each fed by a registered ROM model.
module tb_jogo_memoria_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar0, jogar8;
  logic [3:0] botoes0, mem_dado0, leds0;
  logic [7:0] botoes8, mem_dado8, leds8;
  logic [1:0] mem_end0, rodada0;
  logic [0:0] mem_end8, rodada8;
  logic       pronto0, ganhou0, perdeu0, timeout0, correta0;
  logic       pronto8, ganhou8, perdeu8, timeout8, correta8;
  logic [3:0] estado0, estado8;

  int checks = 0;
  int errors = 0;

  logic [3:0] rom0 [0:3];
  logic [7:0] rom8 [0:1];

  always #5 clock = ~clock;

  jogo_memoria_param #(.N_BOTOES(4), .N_RODADAS(4), .TIMEOUT_CICLOS(50)) dut0 (
    .clock(clock), .reset(reset), .jogar(jogar0), .botoes(botoes0),
    .mem_dado(mem_dado0), .mem_endereco(mem_end0), .leds(leds0),
    .pronto(pronto0), .ganhou(ganhou0), .perdeu(perdeu0), .timeout(timeout0),
    .db_estado(estado0), .db_rodada(rodada0), .db_jogada_correta(correta0)
  );

  jogo_memoria_param #(.N_BOTOES(8), .N_RODADAS(1), .TIMEOUT_CICLOS(50)) dut8 (
    .clock(clock), .reset(reset), .jogar(jogar8), .botoes(botoes8),
    .mem_dado(mem_dado8), .mem_endereco(mem_end8), .leds(leds8),
    .pronto(pronto8), .ganhou(ganhou8), .perdeu(perdeu8), .timeout(timeout8),
    .db_estado(estado8), .db_rodada(rodada8), .db_jogada_correta(correta8)
  );

  // Synchronous ROMs with one cycle of read latency.
  always_ff @(posedge clock) begin
    mem_dado0 <= rom0[mem_end0];
    mem_dado8 <= rom8[mem_end8];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start0();
    jogar0 = 1'b1;
    tick();
    jogar0 = 1'b0;
    tick();
    tick();
  endtask

  task automatic press0(input logic [3:0] v);
    botoes0 = v;
    repeat (5) tick();
    botoes0 = 4'b0000;
    repeat (5) tick();
  endtask

  initial begin
    rom0[0] = 4'b0001; rom0[1] = 4'b0010; rom0[2] = 4'b0100; rom0[3] = 4'b1000;
    rom8[0] = 8'b1000_0000; rom8[1] = 8'b0000_0000;
    reset = 1'b1; jogar0 = 1'b0; jogar8 = 1'b0; botoes0 = '0; botoes8 = '0;
    repeat (2) tick();

    check("reset_estado", estado0, 4'h0);
    check("reset_leds", leds0, 4'h0);
    check("reset_end", mem_end0, 2'd0);
    check("reset_pronto", pronto0, 1'b0);
    reset = 1'b0;
    tick();
    check("inicial_hold", estado0, 4'h0);

    // Start timing: preparacao, inicia_rodada, espera_jogada on consecutive edges.
    jogar0 = 1'b1;
    tick();
    check("start_prep", estado0, 4'h1);
    jogar0 = 1'b0;
    tick();
    check("start_inicia", estado0, 4'h2);
    tick();
    check("start_espera", estado0, 4'h3);

    // First play traced edge by edge.
    botoes0 = 4'b0001;
    tick();
    check("p0_registra", estado0, 4'h4);
    tick();
    check("p0_compara", estado0, 4'h5);
    check("p0_leds", leds0, 4'b0001);
    tick();
    check("p0_prox_rodada", estado0, 4'h7);
    check("p0_correta", correta0, 1'b1);
    repeat (2) tick();
    botoes0 = 4'b0000;
    repeat (5) tick();
    check("r1_espera", estado0, 4'h3);
    check("r1_rodada", rodada0, 2'd1);

    press0(4'b0001); press0(4'b0010);
    press0(4'b0001); press0(4'b0010); press0(4'b0100);
    press0(4'b0001); press0(4'b0010); press0(4'b0100); press0(4'b1000);
    check("win_ganhou", ganhou0, 1'b1);
    check("win_pronto", pronto0, 1'b1);
    check("win_perdeu", perdeu0, 1'b0);
    check("win_estado", estado0, 4'hA);
    check("win_rodada", rodada0, 2'd3);
    check("win_leds", leds0, 4'b1000);

    // New game from fim_ganhou, wrong third play in round 2.
    start0();
    check("g2_estado", estado0, 4'h3);
    check("g2_rodada", rodada0, 2'd0);
    check("g2_leds", leds0, 4'h0);
    check("g2_ganhou", ganhou0, 1'b0);
    press0(4'b0001);
    press0(4'b0001); press0(4'b0010);
    press0(4'b0001); press0(4'b0010); press0(4'b0001);
    check("loss_perdeu", perdeu0, 1'b1);
    check("loss_ganhou", ganhou0, 1'b0);
    check("loss_leds", leds0, 4'b0001);
    check("loss_estado", estado0, 4'hE);
    check("loss_rodada", rodada0, 2'd2);
    check("loss_correta", correta0, 1'b0);
    check("loss_timeout", timeout0, 1'b0);

    // jogar after fim_perdeu restarts at round 0; multi-button press loses.
    start0();
    check("g3_rodada", rodada0, 2'd0);
    check("g3_perdeu", perdeu0, 1'b0);
    press0(4'b0011);
    check("multi_perdeu", perdeu0, 1'b1);
    check("multi_estado", estado0, 4'hE);
    check("multi_leds", leds0, 4'b0011);

    // Long hold counts once; mid-round jogar ignored; mid-round reset clears.
    start0();
    botoes0 = 4'b0001;
    repeat (20) tick();
    botoes0 = 4'b0000;
    repeat (5) tick();
    check("hold_estado", estado0, 4'h3);
    check("hold_rodada", rodada0, 2'd1);
    check("hold_end", mem_end0, 2'd0);
    jogar0 = 1'b1;
    tick();
    jogar0 = 1'b0;
    tick();
    check("jogar_ign_estado", estado0, 4'h3);
    check("jogar_ign_rodada", rodada0, 2'd1);
    press0(4'b0001);
    check("r1p1_estado", estado0, 4'h3);
    check("r1p1_end", mem_end0, 2'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_estado", estado0, 4'h0);
    check("rst_mid_leds", leds0, 4'h0);
    check("rst_mid_end", mem_end0, 2'd0);
    check("rst_mid_rodada", rodada0, 2'd0);
    check("rst_mid_correta", correta0, 1'b0);

    start0();
`ifdef JOGO_MEMORIA_TIMEOUT_EN
    repeat (49) tick();
    check("tmo_before", estado0, 4'h3);
    check("tmo_before_flag", timeout0, 1'b0);
    tick();
    check("tmo_estado", estado0, 4'hF);
    check("tmo_timeout", timeout0, 1'b1);
    check("tmo_perdeu", perdeu0, 1'b1);
    check("tmo_pronto", pronto0, 1'b1);
`else
    repeat (1000) tick();
    check("no_tmo_estado", estado0, 4'h3);
    check("no_tmo_flag", timeout0, 1'b0);
`endif

    // Single-round, 8-button instance.
    jogar8 = 1'b1;
    tick();
    jogar8 = 1'b0;
    tick();
    tick();
    check("n8_espera", estado8, 4'h3);
    botoes8 = 8'b1000_0000;
    tick();
    tick();
    check("n8_compara", estado8, 4'h5);
    check("n8_leds", leds8, 8'b1000_0000);
    check("n8_not_yet", ganhou8, 1'b0);
    tick();
    check("n8_ganhou", ganhou8, 1'b1);
    check("n8_estado", estado8, 4'hA);
    check("n8_rodada", rodada8, 1'b0);
    botoes8 = 8'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jogo_memoria_param.md
# jogo_memoria_param

Parametrised controller for the sequence-memory game, successor to the fixed 4-button, 16-round game datapath. It takes N one-hot buttons and reads the reference sequence from an external synchronous ROM. It then runs rounds of growing length, reporting win, loss and timeout. The block sits between the board I/O (buttons, LEDs, 7-segment debug decoders) and the sequence ROM, replacing the hard-wired control unit and datapath pair.

## Interface
- N_BOTOES, 4: number of buttons/LEDs (2..8); one-hot sequence width.
- N_RODADAS, 16: number of rounds to win (1..256); round r needs r+1 plays.
- TIMEOUT_CICLOS, 5000: clock cycles allowed per play while waiting (≥2).
- LARG_END, $clog2(N_RODADAS) (min 1): ROM address and rodada width.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- jogar  in  1  start request, level-sampled; honoured only in inicial/final states.
- botoes  in  N_BOTOES  raw button levels, already synchronised upstream.
- mem_dado  in  N_BOTOES  ROM data for mem_endereco, valid one cycle after the address changes.
- mem_endereco  out  LARG_END  registered ROM address = current play index.
- leds  out  N_BOTOES  last registered play; 0 outside play.
- pronto  out  1  game finished (any outcome).
- ganhou  out  1  all rounds completed correctly.
- perdeu  out  1  wrong play, illegal press or timeout.
- timeout  out  1  loss caused by timeout.
- db_estado  out  4  state code.
- db_rodada  out  LARG_END  current round index.
- db_jogada_correta  out  1  last compared play matched.

## Operation
- States and codes: inicial(0), preparacao(1), inicia_rodada(2), espera_jogada(3), registra(4), compara(5), proxima_jogada(6), proxima_rodada(7), fim_ganhou(A), fim_perdeu(E), fim_timeout(F).
- inicial: all outputs 0. Go to preparacao when jogar=1.
- preparacao: clear rodada, play index, leds and the timeout counter. Then go to inicia_rodada.
- inicia_rodada: play index := 0, mem_endereco := 0. Then go to espera_jogada.
- espera_jogada: a press event is botoes≠0 while the botoes register from the previous cycle is 0.
  - On a press event, latch botoes into jogada and go to registra.
  - Holding the buttons never produces a second event; all buttons must be released first.
- registra: leds := jogada. Then go to compara.
- compara: correct = (jogada == mem_dado) AND jogada is one-hot.
  - Multi-button presses are always wrong.
  - If wrong, go to fim_perdeu.
  - If correct and play index < rodada, go to proxima_jogada.
  - If correct and play index == rodada == N_RODADAS-1, go to fim_ganhou.
  - Otherwise go to proxima_rodada.
- proxima_jogada: play index +1, mem_endereco follows. Then go to espera_jogada.
- proxima_rodada: rodada +1. Then go to inicia_rodada.
- Final states:
  - All final states: pronto=1.
  - fim_ganhou: ganhou=1.
  - fim_perdeu: perdeu=1.
  - fim_timeout: perdeu=1 and timeout=1.
  - Outputs hold until jogar=1, which goes to preparacao (new game, round 0).
- jogar is ignored in every non-final, non-inicial state.
- Counters never wrap. rodada saturates at N_RODADAS-1 by construction.

## Timing
- Reset: state inicial; mem_endereco, leds, rodada, counters and flags all 0. Reset takes effect on the edge where it is sampled high, mid-game included. It has priority over jogar and botoes.
- jogar sampled high at edge k in inicial/final: preparacao at k+1, inicia_rodada at k+2, espera_jogada at k+3.
- Press first seen at edge k in espera_jogada: registra at k+1, leds valid at k+2 (compara). Outcome state or proxima_* at k+3.
- mem_dado is sampled in compara. The address has been stable for ≥2 cycles by then, so 1-cycle ROM latency is met.
- Press and timeout expiry on the same edge: the press wins.

## Configuration
- JOGO_MEMORIA_TIMEOUT_EN defined:
  - The timeout counter counts cycles spent in espera_jogada and clears on leaving it.
  - When the count reaches TIMEOUT_CICLOS-1 with no press, go to fim_timeout.
- JOGO_MEMORIA_TIMEOUT_EN undefined:
  - No counter is synthesised; espera_jogada waits indefinitely.
  - fim_timeout is unreachable and timeout is tied to 0.

## Test plan
- N_BOTOES=4, N_RODADAS=4, ROM = 0001,0010,0100,1000, all 10 plays correct (5-cycle press, 5-cycle release) -> ganhou=1, pronto=1, db_estado=A, db_rodada=3.
- Same ROM, round 2 third play pressed 0001 instead of 0100 -> perdeu=1, ganhou=0, leds=0001, db_estado=E, db_rodada=2.
- TIMEOUT_EN defined, TIMEOUT_CICLOS=50, no press after start -> timeout=1, perdeu=1 exactly 50 cycles after entering espera_jogada. Undefined: still state 3 after 1000 cycles.
- Press 0011 on first play -> perdeu=1. Hold 0001 for 20 cycles -> counted as exactly one play.
- jogar pulsed mid-round -> ignored. reset mid-round -> all outputs 0, db_estado=0. jogar after fim_perdeu -> new game at db_rodada=0.
- N_BOTOES=8, N_RODADAS=1, ROM[0]=10000000, single correct press -> ganhou=1 three cycles after the press is sampled.
